// File: rtl/rr_arb_mux_if.sv
// Channel-side and output-side handshake bundle for rr_arb_mux.
// The master drives sources, select override and downstream ready; the slave is the mux.
interface rr_arb_mux_if #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_CH     = 4
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_ready;
    logic                         sel_en;
    logic [CH_BITS-1:0]           sel;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_BITS-1:0]           out_ch;
    logic                         out_ready;
    logic                         dbg_full;

    modport master (
        output in_valid, in_data, sel_en, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch, dbg_full
    );

    modport slave (
        input  in_valid, in_data, sel_en, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch, dbg_full
    );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered NUM_CH:1 channel mux with round-robin / fixed-priority arbitration
// and a select override; one output register stage sustaining one word per cycle.
module rr_arb_mux #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_CH     = 4,
    parameter int MODE       = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_mux_if.slave  io_bus
);
    localparam int CH_BITS = $clog2(NUM_CH);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CH_BITS-1:0]    r_ch;
    logic [CH_BITS-1:0]    r_ptr;

    logic                  w_load_en;
    logic [NUM_CH-1:0]     w_eligible;
    logic [NUM_CH-1:0]     w_grant;
    logic                  w_found;
    logic [CH_BITS-1:0]    w_gidx;
    logic [CH_BITS-1:0]    w_idx;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_word;

    // Handshake: a word moves on channel i at a rising edge where in_valid[i] and
    // in_ready[i] are both high; the output word leaves where out_valid and out_ready are.
    assign w_load_en = (r_state == ST_EMPTY) | io_bus.out_ready;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_eligible[i] = io_bus.in_valid[i] &
                            (!io_bus.sel_en | (io_bus.sel == CH_BITS'(i)));
        end
    end

    // Search order starts at the rr pointer in MODE 0 and at ch0 in MODE 1.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (MODE == 1) w_idx = CH_BITS'(k);
            else           w_idx = CH_BITS'((int'(r_ptr) + k) % NUM_CH);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        w_word  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_found && (w_gidx == CH_BITS'(i))) begin
                w_grant[i] = 1'b1;
                w_word     = io_bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer          = w_found & w_load_en;
    assign io_bus.in_ready = w_grant & {NUM_CH{w_load_en & rst_n}};

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer)         w_state_nxt = ST_FULL;
        else if (w_load_en) w_state_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_ch   <= '0;
            r_ptr  <= '0;
        end else if (w_xfer) begin
            r_data <= w_word;
            r_ch   <= w_gidx;
            // Forced transfers must not disturb the fairness rotation.
            if ((MODE == 0) && !io_bus.sel_en) begin
                r_ptr <= (w_gidx == CH_BITS'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    assign io_bus.out_valid = (r_state == ST_FULL);
    assign io_bus.out_data  = r_data;
    assign io_bus.out_ch    = r_ch;
    assign io_bus.dbg_full  = (r_state == ST_FULL);
endmodule
